// File: rtl/hopfield_sequencer.sv
// hopfield_sequencer
//   Training/recall controller for hopfield_network. Stores up to NUM_PAT
//   4-bit patterns, presents them to the network with learning enabled for
//   EPOCHS passes, then opens a RECALL window. In that window it counts the
//   spikes of each neuron and reports a thresholded vector with a done pulse.
//
// Ports
//   clk, reset_n        rising-edge clock, synchronous active-low reset
//   pat_wr_en/addr/data write one pattern slot (IDLE only)
//   pat_clr             clear all slot valid bits (IDLE only, beats write)
//   start               one-cycle pulse, sampled in IDLE
//   abort               return to IDLE (priority below reset only)
//   cue_sel             cue slot, latched with start (HOPSEQ_CUE_EN only)
//   spikes_in           spike vector from the network
//   learning_enable     to the network
//   pattern_out         to the network's pattern_input
//   busy                high in every state except IDLE
//   done                one-cycle pulse when recalled is updated
//   recalled            last recall result
//
// Build option
//   HOPSEQ_CUE_EN: adds the cue_sel port and a CUE state between GAP and
//   RECALL that presents slot[cue_sel] for TRAIN_CYCLES cycles.

module hopfield_sequencer #(
    parameter int unsigned N            = 7,
    parameter int unsigned NUM_PAT      = 4,
    parameter int unsigned TRAIN_CYCLES = 64,
    parameter int unsigned EPOCHS       = 2,
    parameter int unsigned WINDOW       = 256,
    parameter int unsigned THRESH       = 4,
    parameter int unsigned CNT_W        = 8,
    localparam int unsigned AW          = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          pat_wr_en,
    input  logic [AW-1:0] pat_wr_addr,
    input  logic [3:0]    pat_wr_data,
    input  logic          pat_clr,
    input  logic          start,
    input  logic          abort,
`ifdef HOPSEQ_CUE_EN
    input  logic [AW-1:0] cue_sel,
`endif
    input  logic [N-1:0]  spikes_in,
    output logic          learning_enable,
    output logic [3:0]    pattern_out,
    output logic          busy,
    output logic          done,
    output logic [N-1:0]  recalled
);

    localparam int unsigned CYC_MAX = (TRAIN_CYCLES > WINDOW) ? TRAIN_CYCLES : WINDOW;
    localparam int unsigned CW      = $clog2(CYC_MAX + 1);
    localparam int unsigned EW      = $clog2(EPOCHS + 1);

    typedef enum logic [2:0] {
        IDLE,
        TRAIN,
        GAP,
`ifdef HOPSEQ_CUE_EN
        CUE,
`endif
        RECALL,
        REPORT
    } state_t;

    state_t             state;
    logic [3:0]         slot_data [NUM_PAT];
    logic [NUM_PAT-1:0] slot_valid;
    logic [AW-1:0]      slot_idx;
    logic [CW-1:0]      cyc;
    logic [EW-1:0]      epoch;
    logic               start_q;
    logic [CNT_W-1:0]   spike_cnt [N];
    logic [CNT_W-1:0]   cnt_inc [N];
    logic [N-1:0]       rec_vec;
    logic               has_valid;
    logic               has_next;
    logic [AW-1:0]      first_idx;
    logic [AW-1:0]      next_idx;
`ifdef HOPSEQ_CUE_EN
    logic [AW-1:0]      cue_q;
`endif

    assign busy = (state != IDLE);

    // Lowest valid slot, and lowest valid slot above the current one.
    // Scanning downwards lets the last hit (lowest index) win.
    always_comb begin
        has_valid = |slot_valid;
        first_idx = '0;
        has_next  = 1'b0;
        next_idx  = '0;
        for (int unsigned i = 0; i < NUM_PAT; i++) begin
            if (slot_valid[NUM_PAT-1-i]) begin
                first_idx = AW'(NUM_PAT - 1 - i);
                if (AW'(NUM_PAT - 1 - i) > slot_idx) begin
                    has_next = 1'b1;
                    next_idx = AW'(NUM_PAT - 1 - i);
                end
            end
        end
    end

    // Saturating spike counters and the thresholded result that includes
    // the final window cycle's spikes.
    always_comb begin
        for (int unsigned k = 0; k < N; k++) begin
            if (spikes_in[k] && (spike_cnt[k] != '1))
                cnt_inc[k] = spike_cnt[k] + 1'b1;
            else
                cnt_inc[k] = spike_cnt[k];
            rec_vec[k] = (32'(cnt_inc[k]) >= THRESH);
        end
    end

    // start is registered once in IDLE; the FSM acts on that copy, so the
    // first TRAIN cycle appears one edge after start is sampled.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state           <= IDLE;
            slot_valid      <= '0;
            slot_idx        <= '0;
            cyc             <= '0;
            epoch           <= '0;
            start_q         <= 1'b0;
            learning_enable <= 1'b0;
            pattern_out     <= '0;
            done            <= 1'b0;
            recalled        <= '0;
            for (int unsigned k = 0; k < N; k++) spike_cnt[k] <= '0;
`ifdef HOPSEQ_CUE_EN
            cue_q           <= '0;
`endif
        end else if (abort) begin
            state           <= IDLE;
            start_q         <= 1'b0;
            learning_enable <= 1'b0;
            pattern_out     <= '0;
            done            <= 1'b0;
        end else begin
            done    <= 1'b0;
            start_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (pat_clr) begin
                        slot_valid <= '0;
                    end else if (pat_wr_en && (32'(pat_wr_addr) < NUM_PAT)) begin
                        slot_data[pat_wr_addr]  <= pat_wr_data;
                        slot_valid[pat_wr_addr] <= 1'b1;
                    end
                    if (start_q && has_valid) begin
                        state           <= TRAIN;
                        slot_idx        <= first_idx;
                        cyc             <= '0;
                        epoch           <= '0;
                        learning_enable <= 1'b1;
                        pattern_out     <= slot_data[first_idx];
                    end else begin
                        start_q <= start && has_valid;
`ifdef HOPSEQ_CUE_EN
                        if (start) cue_q <= cue_sel;
`endif
                    end
                end
                TRAIN: begin
                    if (cyc == CW'(TRAIN_CYCLES - 1)) begin
                        cyc <= '0;
                        if (has_next) begin
                            slot_idx    <= next_idx;
                            pattern_out <= slot_data[next_idx];
                        end else if (epoch == EW'(EPOCHS - 1)) begin
                            state           <= GAP;
                            learning_enable <= 1'b0;
                            pattern_out     <= '0;
                        end else begin
                            epoch       <= epoch + 1'b1;
                            slot_idx    <= first_idx;
                            pattern_out <= slot_data[first_idx];
                        end
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                GAP: begin
                    for (int unsigned k = 0; k < N; k++) spike_cnt[k] <= '0;
                    cyc <= '0;
`ifdef HOPSEQ_CUE_EN
                    state           <= CUE;
                    learning_enable <= 1'b1;
                    pattern_out     <= slot_data[cue_q];
`else
                    state <= RECALL;
`endif
                end
`ifdef HOPSEQ_CUE_EN
                CUE: begin
                    if (cyc == CW'(TRAIN_CYCLES - 1)) begin
                        state           <= RECALL;
                        cyc             <= '0;
                        learning_enable <= 1'b0;
                        pattern_out     <= '0;
                        for (int unsigned k = 0; k < N; k++) spike_cnt[k] <= '0;
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
`endif
                RECALL: begin
                    spike_cnt <= cnt_inc;
                    if (cyc == CW'(WINDOW - 1)) begin
                        state    <= REPORT;
                        recalled <= rec_vec;
                        done     <= 1'b1;
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                REPORT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
